ov7670_capture_scaled: RTL and testbench

- Parametrised successor to the fixed 320x240 OV7670 capture path.
- Assembles 8-bit camera bytes into 16-bit pixels and decimates horizontally and vertically by parameter factors.
- Applies a runtime-selectable pixel mode and a crop window (outside pixels written black). Drives a single-port frame-buffer write interface.
- Adds frame arming, a frame-done pulse, a frame counter and overflow flagging. Sits between the camera pins and the frame-buffer RAM write port, all in the pclk domain.

---
 rtl/ov7670_capture_scaled.sv | 150 +++++++++++++++
 tb/tb_ov7670_capture_scaled.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_scaled.sv
// OV7670 capture path: assembles camera bytes into RGB565 pixels, decimates and crops them,
// and drives a frame-buffer write port with frame arming, counting and overflow reporting.
module ov7670_capture_scaled #(
   parameter int H_OUT  = 320,
   parameter int V_OUT  = 240,
   parameter int H_DEC  = 2,
   parameter int V_DEC  = 2,
   parameter int ADDR_W = 17,
   parameter int CROP_L = 0,
   parameter int CROP_R = 0,
   parameter int CROP_T = 0,
   parameter int CROP_B = 0
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   input  logic              enable,
   input  logic              mode,
   output logic [ADDR_W-1:0] addr,
   output logic [15:0]       dout,
   output logic              we,
   output logic              frame_done,
   output logic [7:0]        frame_count,
   output logic              overflow
);

   localparam int CW = 11;
   localparam logic [3:0]        H_LAST    = 4'(H_DEC - 1);
   localparam logic [3:0]        V_LAST    = 4'(V_DEC - 1);
   localparam logic [CW-1:0]     H_LIM     = CW'(H_OUT);
   localparam logic [CW-1:0]     V_LIM     = CW'(V_OUT);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_OUT);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t state, state_n;
   logic   frame_start;

   logic              vsync_r, href_r, vsync_q, href_q;
   logic [7:0]        d_r, hi;
   logic              phase;
   logic [3:0]        h_mod, v_mod;
   logic [CW-1:0]     h_out, v_out;
   logic [ADDR_W-1:0] line_base;

   logic        vs_rise, href_rise, href_fall;
   logic        pix_done, keep, in_range, crop;
   logic [15:0] pix;

   assign vs_rise   = vsync_r & ~vsync_q;
   assign href_rise = href_r & ~href_q;
   assign href_fall = ~href_r & href_q;
   assign pix_done  = (state == CAPTURE) && href_r && phase;
   assign keep      = (h_mod == 4'd0) && (v_mod == 4'd0);
   assign in_range  = (h_out < H_LIM) && (v_out < V_LIM);
   assign crop      = (int'(h_out) < CROP_L) || (int'(h_out) >= H_OUT - CROP_R) ||
                      (int'(v_out) < CROP_T) || (int'(v_out) >= V_OUT - CROP_B);
   // In YUV mode the phase-0 byte is luma, expanded to a grey RGB565 value.
   assign pix       = mode ? {hi[7:3], hi[7:2], hi[7:3]} : {hi, d_r};

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_n     = state;
      frame_start = 1'b0;
      case (state)
         IDLE:    if (vs_rise && enable) begin
                     state_n     = ARMED;
                     frame_start = 1'b1;
                  end
         ARMED:   if (vs_rise)        frame_start = 1'b1;
                  else if (href_rise) state_n     = CAPTURE;
         CAPTURE: if (vs_rise)        state_n     = DONE;
         DONE:    if (enable) begin
                     state_n     = ARMED;
                     frame_start = 1'b1;
                  end else begin
                     state_n     = IDLE;
                  end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vsync_r <= 1'b0;  href_r <= 1'b0;  d_r <= '0;
         vsync_q <= 1'b0;  href_q <= 1'b0;
         phase <= 1'b0;    hi <= '0;
         h_mod <= '0;      v_mod <= '0;
         h_out <= '0;      v_out <= '0;     line_base <= '0;
         addr <= '0;       dout <= '0;      we <= 1'b0;
         frame_done <= 1'b0;  frame_count <= '0;  overflow <= 1'b0;
      end else begin
         vsync_r <= vsync;
         href_r  <= href;
         d_r     <= d;
         vsync_q <= vsync_r;
         href_q  <= href_r;
         phase   <= href_r ? ~phase : 1'b0;
         if (href_r && !phase) hi <= d_r;

         we         <= 1'b0;
         frame_done <= 1'b0;
         if (state == CAPTURE && vs_rise) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
         end

         if (frame_start) begin
            h_mod <= '0;  v_mod <= '0;
            h_out <= '0;  v_out <= '0;
            line_base <= '0;
            overflow  <= 1'b0;
         end else begin
            if (href_rise) begin
               h_mod <= '0;
               h_out <= '0;
            end else if (pix_done) begin
               h_mod <= (h_mod == H_LAST) ? 4'd0 : h_mod + 4'd1;
               if (keep) begin
                  // Out-of-window pixels are dropped without moving the address.
                  if (in_range) begin
                     we    <= 1'b1;
                     addr  <= line_base + ADDR_W'(h_out);
                     dout  <= crop ? 16'h0000 : pix;
                     h_out <= h_out + 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            if (state == CAPTURE && href_fall) begin
               v_mod <= (v_mod == V_LAST) ? 4'd0 : v_mod + 4'd1;
               if (v_mod == 4'd0 && v_out < V_LIM) begin
                  v_out     <= v_out + 1'b1;
                  line_base <= line_base + LINE_STEP;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ov7670_capture_scaled.sv
// Directed bench for ov7670_capture_scaled on a 4x4 output window with 2x2 decimation and a
// one-pixel crop border on every side.
module tb_ov7670_capture_scaled;

   localparam int HO = 4, VO = 4, HD = 2, VD = 2, AW = 8, CR = 1;

   logic          pclk = 1'b0;
   logic          rst, vsync, href, enable, mode;
   logic [7:0]    d;
   logic [AW-1:0] addr;
   logic [15:0]   dout;
   logic          we, frame_done, overflow;
   logic [7:0]    frame_count;

   ov7670_capture_scaled #(
      .H_OUT(HO), .V_OUT(VO), .H_DEC(HD), .V_DEC(VD), .ADDR_W(AW),
      .CROP_L(CR), .CROP_R(CR), .CROP_T(CR), .CROP_B(CR)
   ) dut (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
      .enable(enable), .mode(mode), .addr(addr), .dout(dout), .we(we),
      .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   logic [AW-1:0] wa[$];
   logic [15:0]   wd[$];
   int            wc[$];
   int fd_cnt = 0, fd_run = 0, fd_max = 0;
   int passed = 0, total = 0;
   int lo_cyc = 0;

   // Write and frame_done monitor, sampled on the falling edge.
   always @(negedge pclk) begin
      if (rst !== 1'b1) begin
         if (we) begin
            wa.push_back(addr);
            wd.push_back(dout);
            wc.push_back(cyc);
         end
         if (frame_done) begin
            fd_cnt++;
            fd_run++;
            if (fd_run > fd_max) fd_max = fd_run;
         end else begin
            fd_run = 0;
         end
      end
   end

   function automatic logic [15:0] exp_pix(int h, int v, logic [15:0] val);
      return (h < CR || h >= HO - CR || v < CR || v >= VO - CR) ? 16'h0000 : val;
   endfunction

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete();
      fd_cnt = 0; fd_run = 0; fd_max = 0;
   endtask

   task automatic send_pixel(input logic [7:0] b_hi, input logic [7:0] b_lo);
      @(negedge pclk); href = 1'b1; d = b_hi;
      @(negedge pclk); d = b_lo; lo_cyc = cyc;
   endtask

   task automatic end_line();
      @(negedge pclk); href = 1'b0; d = 8'h00;
      repeat (3) @(negedge pclk);
   endtask

   task automatic send_line(input int n, input logic [7:0] b_hi, input logic [7:0] b_lo);
      for (int i = 0; i < n; i++) send_pixel(b_hi, b_lo);
      end_line();
   endtask

   task automatic vsync_pulse();
      @(negedge pclk); vsync = 1'b1;
      repeat (3) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic apply_reset();
      rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00;
      repeat (3) @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);
   endtask

   task automatic test_reset();
      enable = 1'b0; mode = 1'b0;
      apply_reset();
      total++; if (we !== 1'b0) $display("FAIL reset_we: got %b expected 0", we); else passed++;
      total++; if (addr !== '0) $display("FAIL reset_addr: got %h expected 0", addr); else passed++;
      total++; if (dout !== 16'h0) $display("FAIL reset_dout: got %h expected 0", dout); else passed++;
      total++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done); else passed++;
      total++; if (frame_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", frame_count); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passed++;
   endtask

   task automatic test_decimation_crop();
      int t0;
      clear_log();
      enable = 1'b1; mode = 1'b0;
      vsync_pulse();
      send_pixel(8'hAB, 8'hCD);
      t0 = lo_cyc;
      for (int i = 1; i < 8; i++) send_pixel(8'hAB, 8'hCD);
      end_line();
      for (int l = 1; l < 8; l++) send_line(8, 8'hAB, 8'hCD);
      vsync_pulse();
      total++; if (wa.size() != 16) $display("FAIL dec_count: got %0d writes expected 16", wa.size()); else passed++;
      total++;
      if (wc.size() == 0) $display("FAIL dec_latency: got no write expected cycle %0d", t0 + 2);
      else if (wc[0] != t0 + 2) $display("FAIL dec_latency: got cycle %0d expected %0d", wc[0], t0 + 2);
      else passed++;
      for (int v = 0; v < VO; v++) begin
         for (int h = 0; h < HO; h++) begin
            int k;
            k = v * HO + h;
            total++;
            if (k >= wa.size())
               $display("FAIL dec_pix%0d: got no write expected addr %0d", k, k);
            else if (wa[k] !== AW'(k) || wd[k] !== exp_pix(h, v, 16'hABCD))
               $display("FAIL dec_pix%0d: got %0d/%h expected %0d/%h", k, wa[k], wd[k], k, exp_pix(h, v, 16'hABCD));
            else passed++;
         end
      end
      total++; if (fd_cnt != 1) $display("FAIL dec_done: got %0d pulses expected 1", fd_cnt); else passed++;
      total++; if (frame_count !== 8'd1) $display("FAIL dec_fcount: got %0d expected 1", frame_count); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL dec_overflow: got %b expected 0", overflow); else passed++;
   endtask

   task automatic test_yuv_mode();
      clear_log();
      mode = 1'b1;
      send_line(6, 8'h00, 8'h00);
      send_line(6, 8'h00, 8'h00);
      send_pixel(8'h00, 8'h00); send_pixel(8'h11, 8'h11); send_pixel(8'hFF, 8'h55);
      send_pixel(8'h22, 8'h22); send_pixel(8'h80, 8'h66); send_pixel(8'h33, 8'h33);
      end_line();
      mode = 1'b0;
      send_line(6, 8'h00, 8'h00);
      send_pixel(8'h00, 8'h00); send_pixel(8'h00, 8'h00); send_pixel(8'h12, 8'h34);
      send_pixel(8'h00, 8'h00); send_pixel(8'h00, 8'h00); send_pixel(8'h00, 8'h00);
      end_line();
      vsync_pulse();
      total++; if (wa.size() != 9) $display("FAIL yuv_count: got %0d writes expected 9", wa.size()); else passed++;
      if (wa.size() == 9) begin
         total++; if (wa[4] !== AW'(5) || wd[4] !== 16'hFFFF) $display("FAIL yuv_white: got %0d/%h expected 5/ffff", wa[4], wd[4]); else passed++;
         total++; if (wa[5] !== AW'(6) || wd[5] !== 16'h8410) $display("FAIL yuv_grey: got %0d/%h expected 6/8410", wa[5], wd[5]); else passed++;
         total++; if (wa[7] !== AW'(9) || wd[7] !== 16'h1234) $display("FAIL yuv_back_rgb: got %0d/%h expected 9/1234", wa[7], wd[7]); else passed++;
      end
      total++; if (frame_count !== 8'd2) $display("FAIL yuv_fcount: got %0d expected 2", frame_count); else passed++;
   endtask

   task automatic test_h_overflow();
      logic [AW-1:0] ea[5] = '{AW'(0), AW'(4), AW'(5), AW'(6), AW'(7)};
      logic [15:0]   ed[5] = '{16'h0000, 16'h0000, 16'h12C2, 16'h14C4, 16'h0000};
      clear_log();
      send_line(2, 8'h55, 8'h55);
      total++; if (overflow !== 1'b0) $display("FAIL hov_short_line: got %b expected 0", overflow); else passed++;
      send_line(2, 8'h55, 8'h55);
      for (int i = 0; i < HO * HD + 4; i++) send_pixel(8'h10 + 8'(i), 8'hC0 + 8'(i));
      end_line();
      total++; if (overflow !== 1'b1) $display("FAIL hov_set: got %b expected 1", overflow); else passed++;
      total++; if (wa.size() != 5) $display("FAIL hov_count: got %0d writes expected 5", wa.size()); else passed++;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (k >= wa.size()) $display("FAIL hov_pix%0d: got no write expected %0d/%h", k, ea[k], ed[k]);
         else if (wa[k] !== ea[k] || wd[k] !== ed[k])
            $display("FAIL hov_pix%0d: got %0d/%h expected %0d/%h", k, wa[k], wd[k], ea[k], ed[k]);
         else passed++;
      end
      vsync_pulse();
      total++; if (overflow !== 1'b0) $display("FAIL hov_clear: got %b expected 0", overflow); else passed++;
      total++; if (frame_count !== 8'd3) $display("FAIL hov_fcount: got %0d expected 3", frame_count); else passed++;
   endtask

   task automatic test_v_overflow();
      clear_log();
      for (int l = 0; l < VO * VD; l++) begin
         for (int p = 0; p < 4; p++) send_pixel(8'(l), 8'(p));
         end_line();
      end
      total++; if (overflow !== 1'b0) $display("FAIL vov_exact: got %b expected 0", overflow); else passed++;
      for (int p = 0; p < 4; p++) send_pixel(8'(VO * VD), 8'(p));
      end_line();
      total++; if (overflow !== 1'b1) $display("FAIL vov_set: got %b expected 1", overflow); else passed++;
      total++; if (wa.size() != 8) $display("FAIL vov_count: got %0d writes expected 8", wa.size()); else passed++;
      if (wa.size() == 8) begin
         total++; if (wa[3] !== AW'(5) || wd[3] !== 16'h0202) $display("FAIL vov_row1: got %0d/%h expected 5/0202", wa[3], wd[3]); else passed++;
         total++; if (wa[5] !== AW'(9) || wd[5] !== 16'h0402) $display("FAIL vov_row2: got %0d/%h expected 9/0402", wa[5], wd[5]); else passed++;
         total++; if (wa[7] !== AW'(13)) $display("FAIL vov_last_addr: got %0d expected 13", wa[7]); else passed++;
      end
      vsync_pulse();
      total++; if (frame_count !== 8'd4) $display("FAIL vov_fcount: got %0d expected 4", frame_count); else passed++;
   endtask

   task automatic test_reset_mid_line();
      int waited;
      clear_log();
      send_line(HO * HD + 4, 8'h01, 8'h02);
      send_line(2, 8'h01, 8'h02);
      send_pixel(8'hAA, 8'hBB); send_pixel(8'hAA, 8'hBB); send_pixel(8'hAA, 8'hBB);
      waited = 0;
      while (we !== 1'b1 && waited < 6) begin
         @(posedge pclk); #1;
         waited++;
      end
      total++;
      if (we !== 1'b1 || addr !== AW'(5) || dout !== 16'hAABB || overflow !== 1'b1)
         $display("FAIL rmid_pre: got we=%b %0d/%h ovf=%b expected we=1 5/aabb ovf=1", we, addr, dout, overflow);
      else passed++;
      rst = 1'b1;
      #1;
      total++; if (we !== 1'b0) $display("FAIL rmid_we: got %b expected 0", we); else passed++;
      total++; if (addr !== '0 || dout !== 16'h0) $display("FAIL rmid_data: got %0d/%h expected 0/0000", addr, dout); else passed++;
      total++; if (frame_count !== 8'd0 || overflow !== 1'b0) $display("FAIL rmid_status: got %0d/%b expected 0/0", frame_count, overflow); else passed++;
      wa.delete(); wd.delete(); wc.delete();
      repeat (2) @(negedge pclk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send_pixel(8'hAA, 8'hBB);
      end_line();
      send_line(4, 8'hAA, 8'hBB);
      total++; if (wa.size() != 0) $display("FAIL rmid_quiet: got %0d writes expected 0", wa.size()); else passed++;
      vsync_pulse();
      send_line(2, 8'hAA, 8'hBB);
      total++;
      if (wa.size() != 1) $display("FAIL rmid_resume: got %0d writes expected 1", wa.size());
      else if (wa[0] !== '0) $display("FAIL rmid_resume: got addr %0d expected 0", wa[0]);
      else passed++;
   endtask

   task automatic test_enable_frames();
      apply_reset();
      clear_log();
      enable = 1'b1;
      vsync_pulse();
      vsync_pulse();
      total++; if (fd_cnt != 0) $display("FAIL en_armed_gap: got %0d pulses expected 0", fd_cnt); else passed++;
      send_line(2, 8'h12, 8'h34);
      vsync_pulse();
      total++; if (wa.size() != 1) $display("FAIL en_frame1: got %0d writes expected 1", wa.size()); else passed++;
      enable = 1'b0;
      send_line(2, 8'h12, 8'h34);
      vsync_pulse();
      total++; if (wa.size() != 2) $display("FAIL en_frame2: got %0d writes expected 2", wa.size()); else passed++;
      wa.delete();
      send_line(2, 8'h12, 8'h34);
      vsync_pulse();
      total++; if (wa.size() != 0) $display("FAIL en_frame3: got %0d writes expected 0", wa.size()); else passed++;
      total++; if (fd_cnt != 2) $display("FAIL en_pulses: got %0d expected 2", fd_cnt); else passed++;
      total++; if (fd_max != 1) $display("FAIL en_pulse_width: got %0d expected 1", fd_max); else passed++;
      total++; if (frame_count !== 8'd2) $display("FAIL en_fcount: got %0d expected 2", frame_count); else passed++;
   endtask

   task automatic test_count_wrap();
      clear_log();
      enable = 1'b1;
      vsync_pulse();
      for (int f = 0; f < 253; f++) begin
         send_line(1, 8'h00, 8'h00);
         vsync_pulse();
      end
      total++; if (frame_count !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", frame_count); else passed++;
      send_line(1, 8'h00, 8'h00);
      vsync_pulse();
      total++; if (frame_count !== 8'd0) $display("FAIL wrap_0: got %0d expected 0", frame_count); else passed++;
      total++; if (fd_cnt != 254) $display("FAIL wrap_pulses: got %0d expected 254", fd_cnt); else passed++;
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00; enable = 1'b0; mode = 1'b0;
      test_reset();
      test_decimation_crop();
      test_yuv_mode();
      test_h_overflow();
      test_v_overflow();
      test_reset_mid_line();
      test_enable_frames();
      test_count_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
